// File: rtl/algo_scb_pkg.sv
// Shared definitions for the nR-or-1W scoreboard: error codes, the read
// pipeline entry tag and the error priority helpers.
package algo_scb_pkg;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MISMATCH = 3'd1;
    localparam logic [2:0] ERR_MISSING  = 3'd2;
    localparam logic [2:0] ERR_SPURIOUS = 3'd3;
    localparam logic [2:0] ERR_PROTOCOL = 3'd4;
    localparam logic [2:0] ERR_RANGE    = 3'd5;

    // Control part of a read pipeline entry; address and expected data
    // travel alongside because their widths are parameters of the user.
    typedef struct packed {
        logic vld;
        logic known;
    } scb_tag_t;

    // Larger rank wins: PROTOCOL > RANGE > MISSING > SPURIOUS > MISMATCH.
    function automatic logic [2:0] err_rank(input logic [2:0] code);
        case (code)
            ERR_PROTOCOL: return 3'd5;
            ERR_RANGE:    return 3'd4;
            ERR_MISSING:  return 3'd3;
            ERR_SPURIOUS: return 3'd2;
            ERR_MISMATCH: return 3'd1;
            default:      return 3'd0;
        endcase
    endfunction

    // True when a candidate strictly outranks the current best. Candidates
    // are offered in ascending port order, so ties keep the lowest port.
    function automatic logic err_wins(input logic [2:0] cand, input logic [2:0] best);
        return err_rank(cand) > err_rank(best);
    endfunction

endpackage

// File: rtl/algo_scb_rdpipe.sv
// One read port's expectation pipeline: a DELAY-deep shift register whose
// head is the read whose response is due in the current cycle.
module algo_scb_rdpipe
    import algo_scb_pkg::*;
#(
    parameter int DELAY   = 2,
    parameter int BITADDR = 13,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               push_known,
    input  logic [BITADDR-1:0] push_adr,
    input  logic [WIDTH-1:0]   push_exp,
    output scb_tag_t           head_tag,
    output logic [BITADDR-1:0] head_adr,
    output logic [WIDTH-1:0]   head_exp
);

    scb_tag_t           tag_q [DELAY];
    logic [BITADDR-1:0] adr_q [DELAY];
    logic [WIDTH-1:0]   exp_q [DELAY];

    // Valid/known tags shift every cycle; a bubble enters when nothing is pushed.
    // NOTE: state registers use non-blocking assignments so every stage samples
    // the previous stage's pre-edge value, which is what makes this a shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DELAY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0].vld   <= push;
            tag_q[0].known <= push & push_known;
            for (int i = 1; i < DELAY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Payload shifts alongside the tags.
    // NOTE: payload is deliberately left out of reset; it is only ever looked
    // at behind a set vld tag, so resetting it would add fan-out for nothing.
    always_ff @(posedge clk) begin
        adr_q[0] <= push_adr;
        exp_q[0] <= push_exp;
        for (int i = 1; i < DELAY; i++) begin
            adr_q[i] <= adr_q[i-1];
            exp_q[i] <= exp_q[i-1];
        end
    end

    assign head_tag = tag_q[DELAY-1];
    assign head_adr = adr_q[DELAY-1];
    assign head_exp = exp_q[DELAY-1];

endmodule

// File: rtl/algo_nror1w_scoreboard.sv
// Cycle-level scoreboard for nR-or-1W multiport memory algorithms. Keeps a
// shadow memory, predicts per-port read data at latency DELAY and captures
// the first data/valid/protocol violation plus a saturating error count.
// Optional build macro ALGO_SCB_SERR_MASK_EN: when defined, a mismatch on a
// port whose rd_serr is set is forgiven; otherwise rd_serr is ignored.
module algo_nror1w_scoreboard
    import algo_scb_pkg::*;
#(
    parameter int NUMRDPT = 4,
    parameter int WIDTH   = 32,
    parameter int NUMADDR = 8192,
    parameter int BITADDR = 13,
    parameter int DELAY   = 2,
    parameter int BITCNT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic                       write,
    input  logic [BITADDR-1:0]         wr_adr,
    input  logic [WIDTH-1:0]           din,
    input  logic [NUMRDPT-1:0]         read,
    input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
    input  logic [NUMRDPT-1:0]         rd_vld,
    input  logic [NUMRDPT-1:0]         rd_serr,
    input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
    output logic                       err,
    output logic [BITCNT-1:0]          err_cnt,
    output logic [2:0]                 err_code,
    output logic [2:0]                 err_port,
    output logic [BITADDR-1:0]         err_adr
);

    localparam int               IDXW    = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
    localparam logic [BITADDR:0] ADR_LIM = NUMADDR[BITADDR:0];

    function automatic logic in_range(input logic [BITADDR-1:0] adr);
        return {1'b0, adr} < ADR_LIM;
    endfunction

    logic [WIDTH-1:0]   mem_q [NUMADDR];
    logic [NUMADDR-1:0] known_q;

    logic [BITADDR-1:0] rd_adr_a  [NUMRDPT];
    scb_tag_t           head_tag  [NUMRDPT];
    logic [BITADDR-1:0] head_adr  [NUMRDPT];
    logic [WIDTH-1:0]   head_exp  [NUMRDPT];
    logic [2:0]         port_code [NUMRDPT];
    logic [BITADDR-1:0] port_adr  [NUMRDPT];
    logic [NUMRDPT-1:0] rd_ok;
    logic [NUMRDPT-1:0] serr_mask;
    logic [IDXW-1:0]    wr_idx;
    logic               proto;
    logic               wr_ok;

    logic               err_q,      err_d;
    logic [BITCNT-1:0]  err_cnt_q,  err_cnt_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [2:0]         err_port_q, err_port_d;
    logic [BITADDR-1:0] err_adr_q,  err_adr_d;
    logic [2:0]         best_code;
    logic [2:0]         best_port;
    logic [BITADDR-1:0] best_adr;
    logic [BITADDR-1:0] low_rd_adr;

`ifdef ALGO_SCB_SERR_MASK_EN
    assign serr_mask = rd_serr;
`else
    logic unused_serr;
    assign unused_serr = ^rd_serr;
    assign serr_mask   = '0;
`endif

    // A write together with any read, or any command while not ready, is illegal;
    // such commands never reach the shadow memory or the read pipelines.
    assign proto  = (write && (|read)) || (!ready && (write || (|read)));
    assign wr_idx = wr_adr[IDXW-1:0];
    assign wr_ok  = write && !proto && in_range(wr_adr);

    for (genvar p = 0; p < NUMRDPT; p++) begin : g_port
        logic [IDXW-1:0] rd_idx;
        assign rd_adr_a[p] = rd_adr[p*BITADDR +: BITADDR];
        assign rd_idx      = rd_adr_a[p][IDXW-1:0];
        assign rd_ok[p]    = read[p] && !proto && in_range(rd_adr_a[p]);

        algo_scb_rdpipe #(
            .DELAY   (DELAY),
            .BITADDR (BITADDR),
            .WIDTH   (WIDTH)
        ) u_rdpipe (
            .clk        (clk),
            .rst        (rst),
            .push       (rd_ok[p]),
            .push_known (known_q[rd_idx]),
            .push_adr   (rd_adr_a[p]),
            .push_exp   (mem_q[rd_idx]),
            .head_tag   (head_tag[p]),
            .head_adr   (head_adr[p]),
            .head_exp   (head_exp[p])
        );
    end

    // Shadow data array; only the known bits need clearing on reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_idx] <= din;
    end

    // Known bits mark addresses written since the last reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) known_q <= '0;
        else if (wr_ok) known_q[wr_idx] <= 1'b1;
    end

    // Per-port worst error; within one port the checks are already in priority order.
    // NOTE: every output of an always_comb gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        for (int p = 0; p < NUMRDPT; p++) begin
            port_code[p] = ERR_NONE;
            port_adr[p]  = '0;
            if (read[p] && !in_range(rd_adr_a[p])) begin
                port_code[p] = ERR_RANGE;
                port_adr[p]  = rd_adr_a[p];
            end else if (head_tag[p].vld && !rd_vld[p]) begin
                port_code[p] = ERR_MISSING;
                port_adr[p]  = head_adr[p];
            end else if (!head_tag[p].vld && rd_vld[p]) begin
                port_code[p] = ERR_SPURIOUS;
            end else if (head_tag[p].vld && head_tag[p].known && !serr_mask[p] &&
                         (rd_dout[p*WIDTH +: WIDTH] != head_exp[p])) begin
                port_code[p] = ERR_MISMATCH;
                port_adr[p]  = head_adr[p];
            end
        end
    end

    // Pick the cycle's winning error: port-independent ones first, then ports in order.
    always_comb begin
        low_rd_adr = '0;
        for (int p = NUMRDPT - 1; p >= 0; p--) begin
            if (read[p]) low_rd_adr = rd_adr_a[p];
        end
        best_code = ERR_NONE;
        best_port = '0;
        best_adr  = '0;
        if (proto) begin
            best_code = ERR_PROTOCOL;
            best_adr  = write ? wr_adr : low_rd_adr;
        end else if (write && !in_range(wr_adr)) begin
            best_code = ERR_RANGE;
            best_adr  = wr_adr;
        end
        for (int p = 0; p < NUMRDPT; p++) begin
            if (err_wins(port_code[p], best_code)) begin
                best_code = port_code[p];
                best_port = 3'(p);
                best_adr  = port_adr[p];
            end
        end
    end

    // Next state of the sticky capture and the saturating counter.
    always_comb begin
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        err_code_d = err_code_q;
        err_port_d = err_port_q;
        err_adr_d  = err_adr_q;
        if (best_code != ERR_NONE) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!err_q) begin
                err_d      = 1'b1;
                err_code_d = best_code;
                err_port_d = best_port;
                err_adr_d  = best_adr;
            end
        end
    end

    // Registered error outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            err_code_q <= ERR_NONE;
            err_port_q <= '0;
            err_adr_q  <= '0;
        end else begin
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            err_code_q <= err_code_d;
            err_port_q <= err_port_d;
            err_adr_q  <= err_adr_d;
        end
    end

    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign err_code = err_code_q;
    assign err_port = err_port_q;
    assign err_adr  = err_adr_q;

endmodule

// File: tb/tb_algo_nror1w_scoreboard.sv
// Self-checking bench for algo_nror1w_scoreboard: directed scenarios plus a
// randomized phase, all compared against a queue-based model of the rules.
module tb_algo_nror1w_scoreboard;

    localparam int NRD = 4;
    localparam int W   = 32;
    localparam int NA  = 8192;
    localparam int BA  = 14;
    localparam int DL  = 2;
    localparam int BC  = 4;

`ifdef ALGO_SCB_SERR_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ready, write;
    logic [BA-1:0]    wr_adr;
    logic [W-1:0]     din;
    logic [NRD-1:0]   read, rd_vld, rd_serr;
    logic [NRD*BA-1:0] rd_adr;
    logic [NRD*W-1:0] rd_dout;
    logic             err;
    logic [BC-1:0]    err_cnt;
    logic [2:0]       err_code, err_port;
    logic [BA-1:0]    err_adr;

    always #5 clk = ~clk;

    algo_nror1w_scoreboard #(
        .NUMRDPT (NRD), .WIDTH (W), .NUMADDR (NA),
        .BITADDR (BA), .DELAY (DL), .BITCNT (BC)
    ) dut (
        .clk (clk), .rst (rst_n), .ready (ready), .write (write),
        .wr_adr (wr_adr), .din (din), .read (read), .rd_adr (rd_adr),
        .rd_vld (rd_vld), .rd_serr (rd_serr), .rd_dout (rd_dout),
        .err (err), .err_cnt (err_cnt), .err_code (err_code),
        .err_port (err_port), .err_adr (err_adr)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        int         adr;
        logic [W-1:0] exp;
        bit         known;
    } pend_t;

    pend_t        pq [NRD][$];
    logic [W-1:0] smem [int];
    bit           sknown [int];
    bit           m_err;
    int           m_cnt, m_code, m_port, m_adr;
    int           b_code, b_port, b_adr;
    int           cyc = 0;
    int           n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int prio(input int code);
        case (code)
            4: return 5;
            5: return 4;
            2: return 3;
            3: return 2;
            1: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic consider(input int c, input int p, input int a);
        if (prio(c) > prio(b_code) || (prio(c) == prio(b_code) && c != 0 && p < b_port)) begin
            b_code = c;
            b_port = p;
            b_adr  = a;
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NRD; p++) pq[p].delete();
        sknown.delete();
        m_err = 0; m_cnt = 0; m_code = 0; m_port = 0; m_adr = 0;
    endtask

    task automatic idle();
        ready = 1'b1; write = 1'b0; wr_adr = '0; din = '0; read = '0; rd_adr = '0;
    endtask

    task automatic set_rd(input int p, input int adr);
        read[p] = 1'b1;
        rd_adr[p*BA +: BA] = BA'(adr);
    endtask

    // One clock cycle: play the memory's responses, evaluate the rules, then
    // compare the registered outputs half a cycle after the edge.
    task automatic tick(input logic [NRD-1:0] drop, input logic [NRD-1:0] corrupt,
                        input logic [NRD-1:0] serr, input logic [NRD-1:0] spur);
        bit    proto;
        bit    due [NRD];
        int    ra [NRD];
        int    wa, low;
        pend_t e;
        for (int p = 0; p < NRD; p++) begin
            ra[p]  = int'(rd_adr[p*BA +: BA]);
            due[p] = pq[p].size() > 0 && pq[p][0].due == cyc;
            if (due[p]) begin
                rd_vld[p] = !drop[p];
                rd_dout[p*W +: W] = (pq[p][0].known ? pq[p][0].exp : W'($urandom))
                                    ^ (corrupt[p] ? 32'h2 : 32'h0);
            end else begin
                rd_vld[p] = spur[p];
                rd_dout[p*W +: W] = W'($urandom);
            end
            rd_serr[p] = serr[p];
        end
        wa = int'(wr_adr);
        b_code = 0; b_port = 0; b_adr = 0;
        proto = (write && read != 0) || (!ready && (write || read != 0));
        if (proto) begin
            low = 0;
            for (int p = NRD - 1; p >= 0; p--) if (read[p]) low = ra[p];
            consider(4, 0, write ? wa : low);
        end
        if (write && wa >= NA) consider(5, 0, wa);
        for (int p = 0; p < NRD; p++) begin
            if (read[p] && ra[p] >= NA) consider(5, p, ra[p]);
            if (due[p]) begin
                e = pq[p].pop_front();
                if (!rd_vld[p]) consider(2, p, e.adr);
                else if (e.known && rd_dout[p*W +: W] != e.exp && !(MASK_EN && serr[p]))
                    consider(1, p, e.adr);
            end else if (rd_vld[p]) begin
                consider(3, p, 0);
            end
        end
        if (b_code != 0) begin
            if (m_cnt < 2**BC - 1) m_cnt++;
            if (!m_err) begin
                m_err = 1; m_code = b_code; m_port = b_port; m_adr = b_adr;
            end
        end
        if (!proto) begin
            for (int p = 0; p < NRD; p++) begin
                if (read[p] && ra[p] < NA) begin
                    e.due   = cyc + DL;
                    e.adr   = ra[p];
                    e.known = sknown.exists(ra[p]);
                    e.exp   = e.known ? smem[ra[p]] : '0;
                    pq[p].push_back(e);
                end
            end
            if (write && wa < NA) begin
                smem[wa]   = din;
                sknown[wa] = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("err",      err,      m_err);
        check("err_cnt",  err_cnt,  m_cnt);
        check("err_code", err_code, m_code);
        check("err_port", err_port, m_port);
        check("err_adr",  err_adr,  m_adr);
    endtask

    task automatic tick0();
        tick('0, '0, '0, '0);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check("rst_err",  err,      0);
        check("rst_cnt",  err_cnt,  0);
        check("rst_code", err_code, 0);
        check("rst_port", err_port, 0);
        check("rst_adr",  err_adr,  0);
        model_reset();
        idle();
        rd_vld = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NRD-1:0] drop, corr, serr, spur;
        int r, a;

        idle();
        rd_vld = '0; rd_serr = '0; rd_dout = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_err",  err,      0);
        check("init_cnt",  err_cnt,  0);
        check("init_code", err_code, 0);
        rst_n = 1'b1;

        // Matching read-back on all ports.
        idle(); write = 1; wr_adr = 5; din = 32'hDEADBEEF; tick0();
        idle(); for (int p = 0; p < NRD; p++) set_rd(p, 5); tick0();
        idle(); tick0();
        tick0();
        check("t1_err", err, 0);
        check("t1_cnt", err_cnt, 0);

        // Data mismatch on port 2: returned 0x3 for stored 0x1.
        idle(); write = 1; wr_adr = 7; din = 32'h1; tick0();
        idle(); set_rd(2, 7); tick0();
        idle(); tick0();
        tick('0, 4'b0100, '0, '0);
        check("t2_err",  err, 1);
        check("t2_code", err_code, 1);
        check("t2_port", err_port, 2);
        check("t2_adr",  err_adr, 7);
        check("t2_cnt",  err_cnt, 1);

        // Missing response on port 1, then a spurious one on port 3.
        reset_mid();
        idle(); set_rd(1, 9); tick0();
        idle(); tick0();
        tick(4'b0010, '0, '0, '0);
        check("t3_code", err_code, 2);
        check("t3_port", err_port, 1);
        check("t3_adr",  err_adr, 9);
        tick('0, '0, '0, 4'b1000);
        check("t3_cnt2", err_cnt, 2);
        check("t3_hold", err_code, 2);

        // Write with read in the same cycle.
        reset_mid();
        idle(); write = 1; wr_adr = 4; din = 32'h77; set_rd(0, 6); tick0();
        check("t4_code", err_code, 4);
        check("t4_adr",  err_adr, 4);

        // Out-of-range read address.
        reset_mid();
        idle(); set_rd(2, 9000); tick0();
        check("t4r_code", err_code, 5);
        check("t4r_port", err_port, 2);
        check("t4r_adr",  err_adr, 9000);

        // Mismatch flagged as suspect by rd_serr.
        reset_mid();
        idle(); write = 1; wr_adr = 11; din = 32'h55; tick0();
        idle(); set_rd(0, 11); tick0();
        idle(); tick0();
        tick('0, 4'b0001, 4'b0001, '0);
        check("t5_err", err, MASK_EN ? 0 : 1);

        // Counter saturation, then reset with a read in flight.
        reset_mid();
        idle();
        repeat (2**BC + 3) tick('0, '0, '0, 4'b1000);
        check("sat_cnt",  err_cnt, 15);
        check("sat_code", err_code, 3);
        check("sat_port", err_port, 3);
        idle(); set_rd(0, 3); tick0();
        reset_mid();
        tick('0, '0, '0, 4'b0001);
        check("late_code", err_code, 3);
        check("late_port", err_port, 0);
        check("late_cnt",  err_cnt, 1);

        // Randomized traffic with sparse faults and periodic resets.
        reset_mid();
        for (int i = 0; i < 1500; i++) begin
            idle();
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 19) == 0) ? NA + $urandom_range(0, 500) : $urandom_range(0, 15);
            if (r < 35) begin
                write = 1; wr_adr = BA'(a); din = W'($urandom);
            end else if (r < 75) begin
                for (int p = 0; p < NRD; p++)
                    if ($urandom_range(0, 2) == 0)
                        set_rd(p, ($urandom_range(0, 24) == 0) ? NA + 7 : $urandom_range(0, 15));
            end else if (r < 79) begin
                write = 1; wr_adr = BA'(a); din = W'($urandom); set_rd($urandom_range(0, NRD - 1), a);
            end else if (r < 83) begin
                ready = 0;
                if ($urandom_range(0, 1) == 0) begin write = 1; wr_adr = BA'(a); end
                else set_rd($urandom_range(0, NRD - 1), a);
            end
            drop = ($urandom_range(0, 39) == 0) ? NRD'($urandom) : '0;
            corr = ($urandom_range(0, 29) == 0) ? NRD'($urandom) : '0;
            spur = ($urandom_range(0, 49) == 0) ? NRD'($urandom) : '0;
            serr = ($urandom_range(0, 4) == 0)  ? NRD'($urandom) : '0;
            tick(drop, corr, serr, spur);
            if ($urandom_range(0, 39) == 0) reset_mid();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
